// File: rtl/nfca_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nfca_pkg
// Brief    : ISO14443A receive constants and the byte-assembler state enum.
// Revision : 1.0 - initial release
// ============================================================================
package nfca_pkg;

  // Byte-assembler frame states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // no bit received yet in this frame
    ST_DATA = 2'd1,   // collecting data bits
    ST_PAR  = 2'd2,   // eight data bits held, parity bit expected
    ST_DONE = 2'd3    // frame closed, waiting for rx_on to drop
  } nfca_state_e;

  // Data bits per ISO14443A byte
  localparam logic [3:0] NFCA_DATA_BITS = 4'd8;

  // Odd parity: the XOR of the data bits and the parity bit equals this value
  localparam logic NFCA_PARITY_ODD = 1'b1;

endpackage : nfca_pkg
`default_nettype wire

// File: rtl/nfca_rx_tobytes.sv
`default_nettype none
// ============================================================================
// Module   : nfca_rx_tobytes
// Brief    : Assembles ISO14443A parser bits (LSB first, odd parity after
//            each byte) into bytes and reports frame end, length and flags.
// Revision : 1.0 - initial release
// ============================================================================
module nfca_rx_tobytes
  import nfca_pkg::*;
#(
  parameter int MAX_BYTES = 64,
  parameter int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_on,
  input  logic          rx_bit_en,
  input  logic          rx_bit,
  input  logic          rx_end,
  input  logic          rx_end_col,
  input  logic          rx_end_err,
  output logic          rx_byte_en,
  output logic [7:0]    rx_byte,
  output logic [3:0]    rx_byte_nbits,
  output logic          rx_byte_parerr,
  output logic          rx_frame_end,
  output logic          rx_frame_col,
  output logic          rx_frame_err,
  output logic          rx_frame_parerr,
  output logic [LW-1:0] rx_frame_len
);

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BYTES);
  localparam logic [LW-1:0] ONE_LEN = LW'(1);

  nfca_state_e   state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [LW-1:0] bytecnt_q, bytecnt_d;
  logic          sticky_q, sticky_d;

  logic          byte_en_q, byte_en_d;
  logic [7:0]    byte_q, byte_d;
  logic [3:0]    nbits_q, nbits_d;
  logic          byte_perr_q, byte_perr_d;
  logic          fend_q, fend_d;
  logic          fcol_q, fcol_d;
  logic          ferr_q, ferr_d;
  logic          fperr_q, fperr_d;
  logic [LW-1:0] flen_q, flen_d;

  logic          par_exp;
  logic          par_bad;
  logic          full;

  assign par_exp = (^shreg_q) ^ NFCA_PARITY_ODD;
  assign par_bad = (rx_bit != par_exp);
  // A further byte, complete or partial, would exceed the frame limit
  assign full    = (bytecnt_q == MAX_LEN);

  // Next-state and output computation; rx_end always wins over rx_bit_en
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    bytecnt_d   = bytecnt_q;
    sticky_d    = sticky_q;
    byte_en_d   = 1'b0;
    byte_d      = byte_q;
    nbits_d     = nbits_q;
    byte_perr_d = byte_perr_q;
    fend_d      = 1'b0;
    fcol_d      = fcol_q;
    ferr_d      = ferr_q;
    fperr_d     = fperr_q;
    flen_d      = flen_q;

    if (!rx_on) begin
      // Flush: discard any frame in progress without pulsing outputs
      state_d   = ST_IDLE;
      bitcnt_d  = 4'd0;
      shreg_d   = 8'd0;
      bytecnt_d = '0;
      sticky_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_end) begin
            fend_d  = 1'b1;
            fcol_d  = rx_end_col;
            ferr_d  = rx_end_err;
            fperr_d = 1'b0;
            flen_d  = '0;
            state_d = ST_DONE;
          end else if (rx_bit_en) begin
            shreg_d  = {7'd0, rx_bit};
            bitcnt_d = 4'd1;
            state_d  = ST_DATA;
          end
        end

        ST_DATA: begin
          if (rx_end) begin
            fend_d  = 1'b1;
            fcol_d  = rx_end_col;
            ferr_d  = rx_end_err;
            fperr_d = sticky_q;
            flen_d  = bytecnt_q;
            state_d = ST_DONE;
            if (bitcnt_q != 4'd0) begin
              if (full) begin
                // Partial byte beyond the limit is dropped as an overflow
                ferr_d = 1'b1;
              end else begin
                byte_en_d   = 1'b1;
                byte_d      = shreg_q;
                nbits_d     = bitcnt_q;
                byte_perr_d = 1'b0;
                flen_d      = bytecnt_q + ONE_LEN;
              end
            end
          end else if (rx_bit_en) begin
            shreg_d[bitcnt_q[2:0]] = rx_bit;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == NFCA_DATA_BITS - 4'd1) begin
              state_d = ST_PAR;
            end
          end
        end

        ST_PAR: begin
          if (rx_end) begin
            fend_d  = 1'b1;
            fcol_d  = rx_end_col;
            ferr_d  = rx_end_err;
            fperr_d = sticky_q;
            flen_d  = bytecnt_q;
            state_d = ST_DONE;
            if (full) begin
              ferr_d = 1'b1;
            end else begin
              // Missing parity bit counts as a parity error
              byte_en_d   = 1'b1;
              byte_d      = shreg_q;
              nbits_d     = NFCA_DATA_BITS;
              byte_perr_d = 1'b1;
              fperr_d     = 1'b1;
              flen_d      = bytecnt_q + ONE_LEN;
            end
          end else if (rx_bit_en) begin
            if (full) begin
              // Overflow abort: no byte, error-flagged frame end
              fend_d  = 1'b1;
              fcol_d  = 1'b0;
              ferr_d  = 1'b1;
              fperr_d = sticky_q;
              flen_d  = MAX_LEN;
              state_d = ST_DONE;
            end else begin
              byte_en_d   = 1'b1;
              byte_d      = shreg_q;
              nbits_d     = NFCA_DATA_BITS;
              byte_perr_d = par_bad;
              sticky_d    = sticky_q | par_bad;
              bytecnt_d   = bytecnt_q + ONE_LEN;
              bitcnt_d    = 4'd0;
              shreg_d     = 8'd0;
              state_d     = ST_DATA;
            end
          end
        end

        ST_DONE: begin
          // Frame closed; only rx_on=0 reopens reception
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 4'd0;
      shreg_q     <= 8'd0;
      bytecnt_q   <= '0;
      sticky_q    <= 1'b0;
      byte_en_q   <= 1'b0;
      byte_q      <= 8'd0;
      nbits_q     <= 4'd0;
      byte_perr_q <= 1'b0;
      fend_q      <= 1'b0;
      fcol_q      <= 1'b0;
      ferr_q      <= 1'b0;
      fperr_q     <= 1'b0;
      flen_q      <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      bytecnt_q   <= bytecnt_d;
      sticky_q    <= sticky_d;
      byte_en_q   <= byte_en_d;
      byte_q      <= byte_d;
      nbits_q     <= nbits_d;
      byte_perr_q <= byte_perr_d;
      fend_q      <= fend_d;
      fcol_q      <= fcol_d;
      ferr_q      <= ferr_d;
      fperr_q     <= fperr_d;
      flen_q      <= flen_d;
    end
  end

  assign rx_byte_en      = byte_en_q;
  assign rx_byte         = byte_q;
  assign rx_byte_nbits   = nbits_q;
  assign rx_byte_parerr  = byte_perr_q;
  assign rx_frame_end    = fend_q;
  assign rx_frame_col    = fcol_q;
  assign rx_frame_err    = ferr_q;
  assign rx_frame_parerr = fperr_q;
  assign rx_frame_len    = flen_q;

endmodule : nfca_rx_tobytes
`default_nettype wire

// File: tb/tb_nfca_rx_tobytes.sv
`default_nettype none
// ============================================================================
// Module   : tb_nfca_rx_tobytes
// Brief    : Directed self-checking bench for nfca_rx_tobytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nfca_rx_tobytes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_on = 1'b0;
  logic rx_bit_en = 1'b0;
  logic rx_bit = 1'b0;
  logic rx_end = 1'b0;
  logic rx_end_col = 1'b0;
  logic rx_end_err = 1'b0;

  logic       byte_en, byte_pe, fend, fcol, ferr, fpe;
  logic [7:0] byte_v;
  logic [3:0] nbits;
  logic [6:0] flen;

  logic       byte_en2, byte_pe2, fend2, fcol2, ferr2, fpe2;
  logic [7:0] byte_v2;
  logic [3:0] nbits2;
  logic [1:0] flen2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] b;
    logic [3:0] n;
    logic       pe;
    logic       fe;
  } bev_t;

  typedef struct packed {
    logic       col;
    logic       err;
    logic       pe;
    logic [6:0] len;
  } fev_t;

  bev_t bq[$];
  fev_t fq[$];
  bev_t bq2[$];
  fev_t fq2[$];

  nfca_rx_tobytes dut (
    .clk(clk), .rst(rst), .rx_on(rx_on), .rx_bit_en(rx_bit_en), .rx_bit(rx_bit),
    .rx_end(rx_end), .rx_end_col(rx_end_col), .rx_end_err(rx_end_err),
    .rx_byte_en(byte_en), .rx_byte(byte_v), .rx_byte_nbits(nbits),
    .rx_byte_parerr(byte_pe), .rx_frame_end(fend), .rx_frame_col(fcol),
    .rx_frame_err(ferr), .rx_frame_parerr(fpe), .rx_frame_len(flen)
  );

  nfca_rx_tobytes #(.MAX_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .rx_on(rx_on), .rx_bit_en(rx_bit_en), .rx_bit(rx_bit),
    .rx_end(rx_end), .rx_end_col(rx_end_col), .rx_end_err(rx_end_err),
    .rx_byte_en(byte_en2), .rx_byte(byte_v2), .rx_byte_nbits(nbits2),
    .rx_byte_parerr(byte_pe2), .rx_frame_end(fend2), .rx_frame_col(fcol2),
    .rx_frame_err(ferr2), .rx_frame_parerr(fpe2), .rx_frame_len(flen2)
  );

  always #5 clk = ~clk;

  // Record output pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_en)  bq.push_back('{byte_v, nbits, byte_pe, fend});
      if (fend)     fq.push_back('{fcol, ferr, fpe, flen});
      if (byte_en2) bq2.push_back('{byte_v2, nbits2, byte_pe2, fend2});
      if (fend2)    fq2.push_back('{fcol2, ferr2, fpe2, {5'd0, flen2}});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_bit_en = 1'b1;
    rx_bit    = b;
    @(negedge clk);
    rx_bit_en = 1'b0;
    rx_bit    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic par);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(par);
  endtask

  task automatic send_end(input logic col, input logic err, input logic with_bit);
    rx_end     = 1'b1;
    rx_end_col = col;
    rx_end_err = err;
    rx_bit_en  = with_bit;
    rx_bit     = 1'b1;
    @(negedge clk);
    rx_end     = 1'b0;
    rx_end_col = 1'b0;
    rx_end_err = 1'b0;
    rx_bit_en  = 1'b0;
    rx_bit     = 1'b0;
  endtask

  task automatic flush_q();
    bq.delete(); fq.delete(); bq2.delete(); fq2.delete();
  endtask

  // Drop rx_on for two cycles, re-enable, and clear recorded events
  task automatic restart();
    rx_on = 1'b0;
    idle(2);
    rx_on = 1'b1;
    idle(1);
    flush_q();
  endtask

  task automatic chk_byte(input string tag, input bit sel2, input logic [7:0] b,
                          input logic [3:0] n, input logic pe, input logic fe);
    bev_t e;
    bev_t x;
    x = '{b, n, pe, fe};
    if ((sel2 ? bq2.size() : bq.size()) == 0) begin
      chk({tag, "-present"}, 32'd0, 32'd1);
    end else begin
      e = sel2 ? bq2.pop_front() : bq.pop_front();
      chk(tag, {18'd0, e}, {18'd0, x});
    end
  endtask

  task automatic chk_frame(input string tag, input bit sel2, input logic col,
                           input logic err, input logic pe, input logic [6:0] len);
    fev_t e;
    fev_t x;
    x = '{col, err, pe, len};
    if ((sel2 ? fq2.size() : fq.size()) == 0) begin
      chk({tag, "-present"}, 32'd0, 32'd1);
    end else begin
      e = sel2 ? fq2.pop_front() : fq.pop_front();
      chk(tag, {22'd0, e}, {22'd0, x});
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {byte_en, byte_v, nbits, byte_pe, fend, fcol, ferr, fpe, flen,
              byte_en2, byte_v2, nbits2, byte_pe2, fend2, fcol2, ferr2, fpe2}, 32'd0);
    chk({tag, "-len2"}, {30'd0, flen2}, 32'd0);
  endtask

  initial begin
    // Reset state
    idle(3);
    chk_outs_zero("reset");
    rst = 1'b0;
    idle(1);
    rx_on = 1'b1;
    idle(1);
    flush_q();

    // Two correct bytes then end
    send_byte(8'h44, 1'b1);
    send_byte(8'h00, 1'b1);
    send_end(1'b0, 1'b0, 1'b0);
    idle(3);
    chk_byte("f1-b0", 1'b0, 8'h44, 4'd8, 1'b0, 1'b0);
    chk_byte("f1-b1", 1'b0, 8'h00, 4'd8, 1'b0, 1'b0);
    chk_frame("f1-end", 1'b0, 1'b0, 1'b0, 1'b0, 7'd2);
    chk("f1-nomore", bq.size() + fq.size(), 32'd0);
    restart();

    // Wrong parity: 0x93 has four ones, so parity 0 is the error case
    send_byte(8'h93, 1'b0);
    send_end(1'b0, 1'b0, 1'b0);
    idle(3);
    chk_byte("f2-b0", 1'b0, 8'h93, 4'd8, 1'b1, 1'b0);
    chk_frame("f2-end", 1'b0, 1'b0, 1'b0, 1'b1, 7'd1);
    restart();

    // Partial byte with collision
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_end(1'b1, 1'b0, 1'b0);
    idle(3);
    chk_byte("f3-partial", 1'b0, 8'h05, 4'd3, 1'b0, 1'b1);
    chk_frame("f3-end", 1'b0, 1'b1, 1'b0, 1'b0, 7'd1);
    chk("f3-hold", {21'd0, byte_v, flen}, {21'd0, 8'h05, 7'd1});
    // DONE ignores further bits and ends
    send_bit(1'b1);
    send_end(1'b0, 1'b1, 1'b0);
    idle(3);
    chk("f3-done-ignore", bq.size() + fq.size(), 32'd0);
    restart();

    // End while parity expected: missing parity flagged
    for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0);
    send_end(1'b0, 1'b0, 1'b0);
    idle(3);
    chk_byte("f4-nopar", 1'b0, 8'hA5, 4'd8, 1'b1, 1'b1);
    chk_frame("f4-end", 1'b0, 1'b0, 1'b0, 1'b1, 7'd1);
    restart();

    // End with no bits at all, error flag copied
    send_end(1'b0, 1'b1, 1'b0);
    idle(3);
    chk("f5-nobyte", bq.size(), 32'd0);
    chk_frame("f5-end", 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    restart();

    // End at a byte boundary: no byte with the frame end
    send_byte(8'h01, 1'b0);
    send_end(1'b0, 1'b0, 1'b0);
    idle(3);
    chk_byte("f6-b0", 1'b0, 8'h01, 4'd8, 1'b0, 1'b0);
    chk_frame("f6-end", 1'b0, 1'b0, 1'b0, 1'b0, 7'd1);
    chk("f6-nomore", bq.size(), 32'd0);
    restart();

    // Overflow on the 2-byte instance
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(3);
    chk_byte("ov-b0", 1'b1, 8'h11, 4'd8, 1'b0, 1'b0);
    chk_byte("ov-b1", 1'b1, 8'h22, 4'd8, 1'b0, 1'b0);
    chk_frame("ov-end", 1'b1, 1'b0, 1'b1, 1'b0, 7'd2);
    send_bit(1'b1); send_bit(1'b0);
    send_end(1'b1, 1'b0, 1'b0);
    idle(3);
    chk("ov-ignore", bq2.size() + fq2.size(), 32'd0);
    restart();

    // rx_on dropped mid-frame, then a valid frame; end coincides with a bit
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rx_on = 1'b0;
    idle(1);
    rx_on = 1'b1;
    send_byte(8'h5A, 1'b1);
    send_end(1'b0, 1'b0, 1'b1);
    idle(3);
    chk_byte("on-b0", 1'b0, 8'h5A, 4'd8, 1'b0, 1'b0);
    chk_frame("on-end", 1'b0, 1'b0, 1'b0, 1'b0, 7'd1);
    chk("on-nomore", bq.size() + fq.size(), 32'd0);
    restart();

    // Asynchronous reset mid-frame
    for (int i = 0; i < 12; i++) send_bit(i[0]);
    rst = 1'b1;
    #1;
    chk_outs_zero("rst-async");
    @(negedge clk);
    flush_q();
    chk_outs_zero("rst-held");
    rst = 1'b0;
    idle(1);
    send_byte(8'h3C, 1'b1);
    send_end(1'b0, 1'b0, 1'b0);
    idle(3);
    chk_byte("rst-b0", 1'b0, 8'h3C, 4'd8, 1'b0, 1'b0);
    chk_frame("rst-end", 1'b0, 1'b0, 1'b0, 1'b0, 7'd1);
    chk("rst-nomore", bq.size() + fq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nfca_rx_tobytes
`default_nettype wire
